// File: rtl/pu_riscv_wb_pkg.sv
// Shared Wishbone cycle/burst type encodings and arbiter state type for the
// PU-RISCV MMIO arbiter.
package pu_riscv_wb_pkg;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] CONST   = 3'b001;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam logic [1:0] LINEAR  = 2'b00;
    localparam logic [1:0] WRAP4   = 2'b01;
    localparam logic [1:0] WRAP8   = 2'b10;
    localparam logic [1:0] WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        ABORT
    } arb_state_t;

endpackage

// File: rtl/pu_riscv_mmio_arb_wb_if.sv
// Bundle of the two-master / one-slave Wishbone signals around the MMIO arbiter.
// The arbiter uses the slave view; masters and the slave model use the master view.
interface pu_riscv_mmio_arb_wb_if #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32
);
    logic [1:0]              m_cyc_i;
    logic [1:0]              m_stb_i;
    logic [1:0]              m_we_i;
    logic [7:0]              m_sel_i;
    logic [2*HADDR_SIZE-1:0] m_adr_i;
    logic [2*HDATA_SIZE-1:0] m_dat_i;
    logic [5:0]              m_cti_i;
    logic [3:0]              m_bte_i;
    logic [HDATA_SIZE-1:0]   m_dat_o;
    logic [1:0]              m_ack_o;
    logic [1:0]              m_err_o;

    logic                    s_cyc_o;
    logic                    s_stb_o;
    logic                    s_we_o;
    logic [3:0]              s_sel_o;
    logic [HADDR_SIZE-1:0]   s_adr_o;
    logic [HDATA_SIZE-1:0]   s_dat_o;
    logic [2:0]              s_cti_o;
    logic [1:0]              s_bte_o;
    logic [HDATA_SIZE-1:0]   s_dat_i;
    logic                    s_ack_i;
    logic                    s_err_i;

    logic [1:0]              grant_o;
    logic                    timeout_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i, m_bte_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o, s_bte_o,
        output grant_o, timeout_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i, m_bte_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o, s_bte_o,
        input  grant_o, timeout_o
    );

endinterface

// File: rtl/pu_riscv_rr_arb2.sv
// Two-way round-robin winner select with a registered priority pointer.
// The pointer moves to the other master whenever the current owner releases.
module pu_riscv_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       rel,
    input  logic       owner,
    output logic       winner,
    output logic       valid
);

    logic prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (rel) begin
            prio_q <= ~owner;
        end
    end

    always_comb begin
        valid  = |req;
        winner = req[prio_q] ? prio_q : ~prio_q;
    end

endmodule

// File: rtl/pu_riscv_mmio_arb_wb.sv
// Two-master Wishbone arbiter in front of the MMIO simulation slave, with
// cycle-long grants, round-robin ownership and a per-transfer watchdog.
module pu_riscv_mmio_arb_wb
    import pu_riscv_wb_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic                   HCLK,
    input logic                   HRESET,
    pu_riscv_mmio_arb_wb_if.slave bus
);

    localparam int unsigned    CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    arb_state_t      state_q;
    logic            owner_q;
    logic [1:0]      grant_q;
    logic            timeout_q;
    logic [CntW-1:0] cnt_q;

    logic arb_winner;
    logic arb_valid;
    logic rel;
    logic own_cyc;
    logic own_stb;
    logic live;
    logic resp;
    logic expire;

    assign own_cyc = bus.m_cyc_i[owner_q];
    assign own_stb = bus.m_stb_i[owner_q];
    assign live    = !HRESET && (state_q == OWN);
    assign resp    = bus.s_ack_i || bus.s_err_i;
    assign rel     = (state_q != IDLE) && !own_cyc;
    // A response in the expiry cycle wins over the abort.
    assign expire  = (TIMEOUT != 0) && bus.s_stb_o && !resp && (cnt_q == CntLast);

    pu_riscv_rr_arb2 u_arb (
        .clk    (HCLK),
        .rst    (HRESET),
        .req    (bus.m_cyc_i),
        .rel    (rel),
        .owner  (owner_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        state_q <= OWN;
                        owner_q <= arb_winner;
                        grant_q <= {arb_winner, ~arb_winner};
                        cnt_q   <= '0;
                    end
                end
                OWN: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end else if (resp) begin
                        cnt_q <= '0;
                    end else if (expire) begin
                        state_q   <= ABORT;
                        timeout_q <= 1'b1;
                    end else if (bus.s_stb_o) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ABORT: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.s_cyc_o = live && own_cyc;
        bus.s_stb_o = live && own_cyc && own_stb;
        bus.s_we_o  = live && bus.m_we_i[owner_q];
        bus.s_sel_o = owner_q ? bus.m_sel_i[7:4] : bus.m_sel_i[3:0];
        bus.s_adr_o = owner_q ? bus.m_adr_i[2*HADDR_SIZE-1 -: HADDR_SIZE]
                              : bus.m_adr_i[HADDR_SIZE-1:0];
        bus.s_dat_o = owner_q ? bus.m_dat_i[2*HDATA_SIZE-1 -: HDATA_SIZE]
                              : bus.m_dat_i[HDATA_SIZE-1:0];
        bus.s_cti_o = owner_q ? bus.m_cti_i[5:3] : bus.m_cti_i[2:0];
        bus.s_bte_o = owner_q ? bus.m_bte_i[3:2] : bus.m_bte_i[1:0];

        bus.m_dat_o = bus.s_dat_i;
        bus.m_ack_o = 2'b00;
        bus.m_err_o = 2'b00;
        if (live) begin
            bus.m_ack_o[owner_q] = bus.s_ack_i;
            bus.m_err_o[owner_q] = bus.s_err_i;
        end
        // Abort error is a single-cycle pulse on entry to ABORT.
        if (!HRESET && timeout_q) begin
            bus.m_err_o[owner_q] = 1'b1;
        end

        bus.grant_o   = grant_q;
        bus.timeout_o = timeout_q;
    end

endmodule

// File: tb/tb_pu_riscv_mmio_arb_wb.sv
// Scoreboard bench for the MMIO arbiter: a two-master BFM, a stall-programmable
// slave model and a monitor that pops expected transfers at each slave handshake.
module tb_pu_riscv_mmio_arb_wb;
    import pu_riscv_wb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [2:0]  cti;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        m;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [2:0]  cti;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pu_riscv_mmio_arb_wb_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus ();

    pu_riscv_mmio_arb_wb #(
        .HADDR_SIZE (AW),
        .HDATA_SIZE (DW),
        .TIMEOUT    (TO)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h5a5a_0f0f;
    endfunction

    // Master-side drive registers, one process writes them all.
    logic [1:0]  mcyc = '0;
    logic [1:0]  mstb = '0;
    logic [1:0]  mwe  = '0;
    logic [7:0]  msel = '0;
    logic [63:0] madr = '0;
    logic [63:0] mdat = '0;
    logic [5:0]  mcti = '0;
    logic [3:0]  mbte = '0;

    assign bus.m_cyc_i = mcyc;
    assign bus.m_stb_i = mstb;
    assign bus.m_we_i  = mwe;
    assign bus.m_sel_i = msel;
    assign bus.m_adr_i = madr;
    assign bus.m_dat_i = mdat;
    assign bus.m_cti_i = mcti;
    assign bus.m_bte_i = mbte;

    // Slave model: acks after ack_delay stalled cycles; negative never acks.
    int ack_delay = 0;
    int wcnt      = 0;
    always @(posedge clk) begin
        wcnt <= (bus.s_cyc_o && bus.s_stb_o && !bus.s_ack_i) ? wcnt + 1 : 0;
    end
    assign bus.s_ack_i = bus.s_cyc_o && bus.s_stb_o && (ack_delay >= 0) && (wcnt == ack_delay);
    assign bus.s_err_i = 1'b0;
    assign bus.s_dat_i = rd_model(bus.s_adr_o);

    beat_t      mq0[$];
    beat_t      mq1[$];
    exp_t       exp_q[$];
    beat_t      cur[2];
    logic [1:0] busy     = '0;
    logic [1:0] ack_seen = '0;
    logic [1:0] err_seen = '0;

    task automatic add(input int m, input logic [31:0] adr, input logic [31:0] dat,
                       input logic we, input logic [2:0] cti, input logic last,
                       input bit expect_ack);
        beat_t b;
        exp_t  e;
        b.adr = adr; b.dat = dat; b.we = we; b.cti = cti; b.last = last;
        if (m == 0) mq0.push_back(b);
        else        mq1.push_back(b);
        if (expect_ack) begin
            e.m   = (m != 0);
            e.adr = adr;
            e.dat = we ? dat : rd_model(adr);
            e.we  = we;
            e.cti = cti;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input int m, input beat_t b, input logic on);
        mcyc[m]          = on;
        mstb[m]          = on;
        mwe[m]           = on & b.we;
        msel[m*4 +: 4]   = on ? 4'hf : 4'h0;
        madr[m*32 +: 32] = b.adr;
        mdat[m*32 +: 32] = b.dat;
        mcti[m*3 +: 3]   = b.cti;
        mbte[m*2 +: 2]   = LINEAR;
    endtask

    task automatic take(input int m, output beat_t b);
        if (m == 0) b = mq0.pop_front();
        else        b = mq1.pop_front();
    endtask

    task automatic bfm_update();
        beat_t b;
        for (int m = 0; m < 2; m++) begin
            if (busy[m] && (ack_seen[m] || err_seen[m])) begin
                if (cur[m].last || err_seen[m]) begin
                    // On error, discard the rest of this master's cycle.
                    while (err_seen[m] && !cur[m].last &&
                           ((m == 0) ? mq0.size() : mq1.size()) > 0) begin
                        take(m, b);
                        cur[m] = b;
                    end
                    busy[m] = 1'b0;
                    drive(m, cur[m], 1'b0);
                end else begin
                    take(m, b);
                    cur[m] = b;
                    drive(m, cur[m], 1'b1);
                end
            end else if (!busy[m] && ((m == 0) ? mq0.size() : mq1.size()) > 0) begin
                take(m, b);
                cur[m]  = b;
                busy[m] = 1'b1;
                drive(m, cur[m], 1'b1);
            end
        end
    endtask

    // Inputs change 1 time unit after posedge; returns at the following negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        bfm_update();
        @(negedge clk);
        ack_seen = bus.m_ack_o;
        err_seen = bus.m_err_o;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy != 2'b00 || mq0.size() > 0 || mq1.size() > 0 || exp_q.size() > 0 ||
                bus.grant_o != 2'b00) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 200), 64'd1);
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        while (!bus.s_stb_o && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.s_stb_o), 64'd1);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.s_cyc_o && bus.s_stb_o && bus.s_ack_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_grant", 64'(bus.grant_o), e.m ? 64'd2 : 64'd1);
                chk("sb_ack",   64'(bus.m_ack_o), e.m ? 64'd2 : 64'd1);
                chk("sb_adr",   64'(bus.s_adr_o), 64'(e.adr));
                chk("sb_we",    64'(bus.s_we_o),  64'(e.we));
                chk("sb_cti",   64'(bus.s_cti_o), 64'(e.cti));
                chk("sb_dat",   e.we ? 64'(bus.s_dat_o) : 64'(bus.m_dat_o), 64'(e.dat));
            end
        end
    end

    initial begin
        int n;
        @(negedge clk);
        tick();
        tick();
        chk("rst_grant",   64'(bus.grant_o),   64'd0);
        chk("rst_timeout", 64'(bus.timeout_o), 64'd0);
        chk("rst_ack",     64'(bus.m_ack_o),   64'd0);
        chk("rst_err",     64'(bus.m_err_o),   64'd0);

        // Single write from m0.
        #1 rst = 1'b0;
        add(0, 32'h8000_1000, 32'h1, 1'b1, CLASSIC, 1'b1, 1'b1);
        tick();
        chk("t1_cyc_lat0", 64'(bus.s_cyc_o), 64'd0);
        chk("t1_grant0",   64'(bus.grant_o), 64'd0);
        tick();
        chk("t1_cyc_lat1", 64'(bus.s_cyc_o), 64'd1);
        chk("t1_adr",      64'(bus.s_adr_o), 64'h8000_1000);
        chk("t1_sel",      64'(bus.s_sel_o), 64'hf);
        chk("t1_grant",    64'(bus.grant_o), 64'd1);
        chk("t1_ack",      64'(bus.m_ack_o), 64'd1);
        drain("t1_drain");

        // Contention from reset: strict alternation 0,1,0,1.
        #1 rst = 1'b1;
        tick();
        #1 rst = 1'b0;
        add(0, 32'h8000_0100, 32'ha0, 1'b1, CLASSIC, 1'b1, 1'b1);
        add(1, 32'h8000_0200, 32'hb1, 1'b1, CLASSIC, 1'b1, 1'b1);
        add(0, 32'h8000_0104, 32'h0,  1'b0, CLASSIC, 1'b1, 1'b1);
        add(1, 32'h8000_0204, 32'h0,  1'b0, CLASSIC, 1'b1, 1'b1);
        drain("t2_drain");

        // m1 INCR burst, m0 arrives mid-burst and must wait.
        for (int i = 0; i < 4; i++) begin
            add(1, 32'h8000_2000 + 32'(4 * i), 32'hc000 + 32'(i), 1'b1,
                (i == 3) ? EOB : INCR, (i == 3), 1'b1);
        end
        tick();
        tick();
        add(0, 32'h8000_3000, 32'h0, 1'b0, CLASSIC, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_m0_wait", 64'(bus.m_ack_o[0]), 64'd0);
        end
        drain("t3_drain");

        // Watchdog abort with a silent slave.
        #1 ack_delay = -1;
        add(0, 32'h8000_4000, 32'h0, 1'b0, CLASSIC, 1'b1, 1'b0);
        wait_stb("t4_stb");
        n = 0;
        while (!bus.m_err_o[0] && n < 40) begin
            tick();
            n++;
        end
        chk("t4_err_delay", 64'(n),             64'd16);
        chk("t4_timeout",   64'(bus.timeout_o), 64'd1);
        chk("t4_scyc",      64'(bus.s_cyc_o),   64'd0);
        chk("t4_grant",     64'(bus.grant_o),   64'd1);
        tick();
        chk("t4_err_pulse", 64'(bus.m_err_o),   64'd0);
        chk("t4_to_pulse",  64'(bus.timeout_o), 64'd0);
        chk("t4_abort_cyc", 64'(bus.s_cyc_o),   64'd0);
        drain("t4_drain");

        // Ack on the last permitted stalled cycle beats the watchdog.
        #1 ack_delay = 15;
        add(0, 32'h8000_5000, 32'h0, 1'b0, CLASSIC, 1'b1, 1'b1);
        wait_stb("t5_stb");
        n = 0;
        while (!bus.m_ack_o[0] && !bus.m_err_o[0] && n < 40) begin
            tick();
            n++;
        end
        chk("t5_ack_delay", 64'(n),             64'd15);
        chk("t5_err",       64'(bus.m_err_o),   64'd0);
        chk("t5_timeout",   64'(bus.timeout_o), 64'd0);
        tick();
        chk("t5_timeout1",  64'(bus.timeout_o), 64'd0);
        chk("t5_err1",      64'(bus.m_err_o),   64'd0);
        drain("t5_drain");

        // Reset during the second burst beat.
        #1 ack_delay = 2;
        for (int i = 0; i < 4; i++) begin
            add(0, 32'h8000_6000 + 32'(4 * i), 32'hd000 + 32'(i), 1'b1,
                (i == 3) ? EOB : INCR, (i == 3), (i == 0));
        end
        n = 0;
        while (!bus.m_ack_o[0] && n < 20) begin
            tick();
            n++;
        end
        chk("t6_beat0", 64'(bus.m_ack_o[0]), 64'd1);
        tick();
        chk("t6_beat1_adr", 64'(bus.s_adr_o), 64'h8000_6004);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_ack",  64'(bus.m_ack_o), 64'd0);
        chk("t6_rst_scyc", 64'(bus.s_cyc_o), 64'd0);
        tick();
        chk("t6_grant",    64'(bus.grant_o), 64'd0);
        chk("t6_scyc",     64'(bus.s_cyc_o), 64'd0);
        chk("t6_ack",      64'(bus.m_ack_o), 64'd0);
        mq0.delete();
        busy[0]  = 1'b0;
        drive(0, cur[0], 1'b0);
        ack_seen = '0;
        #1 rst = 1'b0;
        add(0, 32'h8000_7000, 32'h77, 1'b1, CLASSIC, 1'b1, 1'b1);
        add(1, 32'h8000_7100, 32'h0,  1'b0, CLASSIC, 1'b1, 1'b1);
        tick();
        tick();
        chk("t6_m0_wins", 64'(bus.grant_o), 64'd1);
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
